// File: rtl/band_energy_detector.sv
// ----------------------------------------------------------------------------
// band_energy_detector
//
// Purpose:
//   Tone detector that sits downstream of the bandpass filter. It rectifies
//   each valid sample and sums the magnitudes over fixed, non-overlapping
//   blocks of 2^LOG2_WINDOW samples. When a block completes, its average is
//   reported and compared against on/off thresholds with hysteresis to drive
//   a tone-present flag.
//
// Ports:
//   clk_in            : system clock
//   rst_in            : synchronous, active-high reset
//   y_in              : signed filter sample, SIG_WIDTH+1 bits
//   y_in_valid        : one-cycle qualifier, y_in sampled on the same edge
//   on_thresh_in      : unsigned assert threshold (sampled in REPORT only)
//   off_thresh_in     : unsigned deassert threshold (sampled in REPORT only)
//   energy_out        : unsigned block-average magnitude, held between reports
//   energy_valid_out  : one-cycle pulse when energy_out updates
//   detect_out        : tone-present level
//   detect_change_out : one-cycle pulse when detect_out toggles
//
// Timing:
//   Edge k samples the block-completing valid and latches the window sum.
//   Edge k+1 ends the one-cycle REPORT state and registers the decision.
//   Edge k+2 moves the decision onto the output registers.
// ----------------------------------------------------------------------------
module band_energy_detector #(
    parameter int SIG_WIDTH   = 8,
    parameter int LOG2_WINDOW = 6
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [SIG_WIDTH:0]   y_in,
    input  logic                 y_in_valid,
    input  logic [SIG_WIDTH:0]   on_thresh_in,
    input  logic [SIG_WIDTH:0]   off_thresh_in,
    output logic [SIG_WIDTH:0]   energy_out,
    output logic                 energy_valid_out,
    output logic                 detect_out,
    output logic                 detect_change_out
);

    // Sum of 2^LOG2_WINDOW magnitudes of at most 2^SIG_WIDTH each.
    localparam int ACC_W = SIG_WIDTH + 1 + LOG2_WINDOW;

    typedef enum logic {
        ACCUM  = 1'b0,
        REPORT = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [ACC_W-1:0]         acc_q, acc_d;
    logic [LOG2_WINDOW-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]         win_q, win_d;

    // Decision stage, written at the end of the REPORT cycle.
    logic [SIG_WIDTH:0]       avg_q, avg_d;
    logic                     avg_valid_q, avg_valid_d;
    logic                     det_q, det_d;
    logic                     det_chg_q, det_chg_d;

    // Output stage.
    logic [SIG_WIDTH:0]       energy_out_q, energy_out_d;
    logic                     energy_valid_out_q, energy_valid_out_d;
    logic                     detect_out_q, detect_out_d;
    logic                     detect_change_out_q, detect_change_out_d;

    logic [SIG_WIDTH:0]       mag;
    logic [ACC_W-1:0]         acc_plus_mag;
    logic [SIG_WIDTH:0]       avg;

    // Two's-complement negate at full input width: the most negative value
    // maps onto 2^SIG_WIDTH, which is representable as an unsigned result.
    always_comb begin
        if (y_in[SIG_WIDTH]) begin
            mag = ~y_in + {{SIG_WIDTH{1'b0}}, 1'b1};
        end else begin
            mag = y_in;
        end
    end

    assign acc_plus_mag = acc_q + {{LOG2_WINDOW{1'b0}}, mag};

    // Truncating divide by the block length; upper bits fit SIG_WIDTH+1.
    assign avg = win_q[ACC_W-1:LOG2_WINDOW];

    always_comb begin
        state_d             = ACCUM;
        acc_d               = acc_q;
        cnt_d               = cnt_q;
        win_d               = win_q;
        avg_d               = avg_q;
        avg_valid_d         = 1'b0;
        det_d               = det_q;
        det_chg_d           = 1'b0;
        energy_out_d        = avg_q;
        energy_valid_out_d  = avg_valid_q;
        detect_out_d        = det_q;
        detect_change_out_d = det_chg_q;

        // Accumulation is independent of the FSM state so a valid landing in
        // the REPORT cycle becomes sample 0 of the next block.
        if (y_in_valid) begin
            if (cnt_q == '1) begin
                win_d   = acc_plus_mag;
                acc_d   = '0;
                cnt_d   = '0;
                state_d = REPORT;
            end else begin
                acc_d = acc_plus_mag;
                cnt_d = cnt_q + {{(LOG2_WINDOW-1){1'b0}}, 1'b1};
            end
        end

        if (state_q == REPORT) begin
            avg_d       = avg;
            avg_valid_d = 1'b1;
            if (!det_q && (avg >= on_thresh_in)) begin
                det_d     = 1'b1;
                det_chg_d = 1'b1;
            end else if (det_q && (avg < off_thresh_in)) begin
                det_d     = 1'b0;
                det_chg_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q             <= ACCUM;
            acc_q               <= '0;
            cnt_q               <= '0;
            win_q               <= '0;
            avg_q               <= '0;
            avg_valid_q         <= 1'b0;
            det_q               <= 1'b0;
            det_chg_q           <= 1'b0;
            energy_out_q        <= '0;
            energy_valid_out_q  <= 1'b0;
            detect_out_q        <= 1'b0;
            detect_change_out_q <= 1'b0;
        end else begin
            state_q             <= state_d;
            acc_q               <= acc_d;
            cnt_q               <= cnt_d;
            win_q               <= win_d;
            avg_q               <= avg_d;
            avg_valid_q         <= avg_valid_d;
            det_q               <= det_d;
            det_chg_q           <= det_chg_d;
            energy_out_q        <= energy_out_d;
            energy_valid_out_q  <= energy_valid_out_d;
            detect_out_q        <= detect_out_d;
            detect_change_out_q <= detect_change_out_d;
        end
    end

    assign energy_out        = energy_out_q;
    assign energy_valid_out  = energy_valid_out_q;
    assign detect_out        = detect_out_q;
    assign detect_change_out = detect_change_out_q;

endmodule
